e_muldiv_unit: RTL and testbench

//  Execute-stage multiply/divide unit owning the HI/LO register pair. It consumes
//  A1_E/A2_E and the decoded MD op of the instruction in the D->E pipeline register.
//  It drives BUSY back to hazard control, which holds that register (EN_E low)

---
 rtl/e_muldiv_unit_pkg.sv | 28 ++
 rtl/e_md_calc.sv | 58 +++++
 rtl/e_muldiv_unit.sv | 98 +++++++++
 tb/tb_e_muldiv_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/e_muldiv_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// MD op encoding, default latencies and small op-class helpers.
package e_muldiv_unit_pkg;

  typedef enum logic [3:0] {
    MdNone  = 4'd0,
    MdMult  = 4'd1,
    MdMultu = 4'd2,
    MdDiv   = 4'd3,
    MdDivu  = 4'd4,
    MdMthi  = 4'd5,
    MdMtlo  = 4'd6,
    MdMfhi  = 4'd7,
    MdMflo  = 4'd8
  } md_op_e;

  localparam int unsigned MulCyclesDef = 5;
  localparam int unsigned DivCyclesDef = 10;

  function automatic logic is_long(input md_op_e op);
    return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
  endfunction

  function automatic logic is_mul(input md_op_e op);
    return (op == MdMult) || (op == MdMultu);
  endfunction

endpackage

// File: rtl/e_md_calc.sv
// Combinational multiply/divide datapath: produces the HI/LO pair for a long MD op
// and flags a division by zero so the commit can be suppressed.
module e_md_calc
  import e_muldiv_unit_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        dbz_o
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] mag_a, mag_b, div_b;
  logic        [31:0] sq_mag, sr_mag, uq, ur;

  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Signed divide via magnitudes; INT_MIN / -1 falls out as 0x80000000 rem 0.
  assign mag_a  = a_i[31] ? (32'd0 - a_i) : a_i;
  assign mag_b  = b_i[31] ? (32'd0 - b_i) : b_i;
  assign div_b  = (b_i == 32'd0) ? 32'd1 : mag_b;
  assign sq_mag = mag_a / div_b;
  assign sr_mag = mag_a % div_b;
  assign uq     = a_i / ((b_i == 32'd0) ? 32'd1 : b_i);
  assign ur     = a_i % ((b_i == 32'd0) ? 32'd1 : b_i);

  always_comb begin
    hi_o  = 32'd0;
    lo_o  = 32'd0;
    dbz_o = 1'b0;
    case (op_i)
      MdMult: begin
        hi_o = prod_s[63:32];
        lo_o = prod_s[31:0];
      end
      MdMultu: begin
        hi_o = prod_u[63:32];
        lo_o = prod_u[31:0];
      end
      MdDiv: begin
        lo_o  = (a_i[31] ^ b_i[31]) ? (32'd0 - sq_mag) : sq_mag;
        hi_o  = a_i[31] ? (32'd0 - sr_mag) : sr_mag;
        dbz_o = (b_i == 32'd0);
      end
      MdDivu: begin
        lo_o  = uq;
        hi_o  = ur;
        dbz_o = (b_i == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_muldiv_unit.sv
// Execute-stage MD unit owning HI/LO: fixed-latency mult/div with deferred commit,
// single-cycle MTHI/MTLO and combinational MFHI/MFLO read-out.
module e_muldiv_unit
  import e_muldiv_unit_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MulCyclesDef,
  parameter int unsigned DIV_CYCLES = DivCyclesDef
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        BUSY,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic [31:0] md_out
);

  localparam int unsigned CntMax = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  md_op_e          op;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic            pend_dbz_q, pend_dbz_d;
  logic [31:0]     calc_hi, calc_lo;
  logic            calc_dbz;
  logic            launch;

  assign op     = md_op_e'(md_op);
  assign BUSY   = (cnt_q != '0);
  assign launch = start && !Req && !BUSY && is_long(op);
  assign HI_out = hi_q;
  assign LO_out = lo_q;

  e_md_calc u_calc (
    .op_i  (op),
    .a_i   (A),
    .b_i   (B),
    .hi_o  (calc_hi),
    .lo_o  (calc_lo),
    .dbz_o (calc_dbz)
  );

  always_comb begin
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    pend_dbz_d = pend_dbz_q;
    if (BUSY) begin
      cnt_d = cnt_q - CntW'(1);
      // Results become architecturally visible only on the final busy edge.
      if ((cnt_q == CntW'(1)) && !pend_dbz_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (launch) begin
      cnt_d      = is_mul(op) ? CntW'(MUL_CYCLES) : CntW'(DIV_CYCLES);
      pend_hi_d  = calc_hi;
      pend_lo_d  = calc_lo;
      pend_dbz_d = calc_dbz;
    end else if (!Req) begin
      if (op == MdMthi) hi_d = A;
      if (op == MdMtlo) lo_d = A;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      pend_hi_q  <= 32'd0;
      pend_lo_q  <= 32'd0;
      pend_dbz_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_dbz_q <= pend_dbz_d;
    end
  end

  always_comb begin
    md_out = 32'd0;
    if (op == MdMfhi)      md_out = hi_q;
    else if (op == MdMflo) md_out = lo_q;
  end

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Self-checking bench for e_muldiv_unit: directed corner cases plus random traffic
// compared every cycle against a timestamp-based behavioural model.
module tb_e_muldiv_unit;

  localparam int MulN = 5;
  localparam int DivN = 10;
  localparam logic [3:0] OpNone = 4'd0, OpMult = 4'd1, OpMultu = 4'd2, OpDiv = 4'd3,
                         OpDivu = 4'd4, OpMthi = 4'd5, OpMtlo = 4'd6, OpMfhi = 4'd7,
                         OpMflo = 4'd8;

  logic        clk = 1'b0;
  logic        reset, Req, start;
  logic [3:0]  md_op;
  logic [31:0] A, B;
  logic        BUSY;
  logic [31:0] HI_out, LO_out, md_out;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: a pending op commits at an absolute edge number.
  longint      m_edge   = 0;
  longint      m_commit = 0;
  bit          m_pend   = 1'b0;
  bit          m_pdbz   = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;

  e_muldiv_unit #(.MUL_CYCLES(MulN), .DIV_CYCLES(DivN)) dut (
    .clk    (clk),
    .reset  (reset),
    .Req    (Req),
    .start  (start),
    .md_op  (md_op),
    .A      (A),
    .B      (B),
    .BUSY   (BUSY),
    .HI_out (HI_out),
    .LO_out (LO_out),
    .md_out (md_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    m_edge++;
    if (reset) begin
      m_pend = 1'b0; m_pdbz = 1'b0;
      m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
    end else if (m_pend) begin
      if (m_edge == m_commit) begin
        if (!m_pdbz) begin
          m_hi = m_phi;
          m_lo = m_plo;
        end
        m_pend = 1'b0;
      end
    end else if (start && !Req && (md_op inside {OpMult, OpMultu, OpDiv, OpDivu})) begin
      m_pend   = 1'b1;
      m_pdbz   = 1'b0;
      m_commit = m_edge + ((md_op == OpMult || md_op == OpMultu) ? MulN : DivN);
      case (md_op)
        OpMult: begin
          sp = longint'($signed(A)) * longint'($signed(B));
          {m_phi, m_plo} = sp;
        end
        OpMultu: begin
          up = longint'(A) * longint'(B);
          {m_phi, m_plo} = up;
        end
        OpDiv: begin
          if (B == 0) m_pdbz = 1'b1;
          else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
            m_plo = 32'h8000_0000; m_phi = 32'h0;
          end else begin
            sa = A; sb = B;
            m_plo = sa / sb;
            m_phi = sa % sb;
          end
        end
        default: begin
          if (B == 0) m_pdbz = 1'b1;
          else begin
            m_plo = A / B;
            m_phi = A % B;
          end
        end
      endcase
    end else if (!Req) begin
      if (md_op == OpMthi) m_hi = A;
      if (md_op == OpMtlo) m_lo = A;
    end
  endtask

  task automatic cyc(input logic rs, input logic rq, input logic st, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b);
    reset = rs; Req = rq; start = st; md_op = op; A = a; B = b;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, OpNone, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Single compare process: every cycle, DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, BUSY}, {31'd0, m_pend});
      check("hi", HI_out, m_hi);
      check("lo", LO_out, m_lo);
      check("md_out", md_out, (md_op == OpMfhi) ? m_hi : (md_op == OpMflo) ? m_lo : 32'd0);
    end
  end

  initial begin
    logic       rs, rq, st;
    logic [3:0] op;
    reset = 1'b1; Req = 1'b0; start = 1'b0; md_op = OpNone; A = '0; B = '0;
    cyc(1'b1, 1'b0, 1'b0, OpNone, 32'd0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, OpNone, 32'd0, 32'd0);
    chk_en = 1'b1;
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_hi", HI_out, 32'd0);
    check("rst_lo", LO_out, 32'd0);

    // MULT -2*3: busy T..T+4, visible at T+5
    cyc(1'b0, 1'b0, 1'b1, OpMult, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy_T", {31'd0, BUSY}, 32'd1);
    idle(4);
    check("mult_busy_T4", {31'd0, BUSY}, 32'd1);
    check("mult_hidden", HI_out, 32'd0);
    idle(1);
    check("mult_done", {31'd0, BUSY}, 32'd0);
    check("mult_hi", HI_out, 32'hFFFF_FFFF);
    check("mult_lo", LO_out, 32'hFFFF_FFFA);

    // MULTU with Req arriving mid-op still commits on time
    cyc(1'b0, 1'b0, 1'b1, OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, OpNone, 32'd0, 32'd0);
    idle(2);
    check("multu_busy_T4", {31'd0, BUSY}, 32'd1);
    idle(1);
    check("multu_hi", HI_out, 32'hFFFF_FFFE);
    check("multu_lo", LO_out, 32'h0000_0001);

    // start together with Req: flushed, no launch
    cyc(1'b0, 1'b1, 1'b1, OpMult, 32'd5, 32'd5);
    check("req_nolaunch", {31'd0, BUSY}, 32'd0);
    check("req_hi", HI_out, 32'hFFFF_FFFE);

    cyc(1'b0, 1'b0, 1'b1, OpDiv, 32'hFFFF_FFF9, 32'd2);
    idle(9);
    check("div_busy_T9", {31'd0, BUSY}, 32'd1);
    idle(1);
    check("div_lo", LO_out, 32'hFFFF_FFFD);
    check("div_hi", HI_out, 32'hFFFF_FFFF);

    cyc(1'b0, 1'b0, 1'b1, OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10);
    check("divovf_lo", LO_out, 32'h8000_0000);
    check("divovf_hi", HI_out, 32'h0);

    // MTHI while busy is dropped; MTLO when idle commits next edge
    cyc(1'b0, 1'b0, 1'b1, OpMult, 32'd2, 32'd3);
    cyc(1'b0, 1'b0, 1'b0, OpMthi, 32'h1234, 32'd0);
    idle(4);
    check("mthi_ignored", HI_out, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, OpMtlo, 32'h55, 32'd0);
    check("mtlo", LO_out, 32'h55);
    cyc(1'b0, 1'b0, 1'b0, OpMflo, 32'd0, 32'd0);
    check("mflo", md_out, 32'h55);
    cyc(1'b0, 1'b0, 1'b0, OpMfhi, 32'd0, 32'd0);
    check("mfhi", md_out, 32'd0);

    // DIVU by zero: full latency, HI/LO untouched
    cyc(1'b0, 1'b0, 1'b0, OpMthi, 32'hABCD, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, OpDivu, 32'd7, 32'd0);
    idle(9);
    check("divz_busy", {31'd0, BUSY}, 32'd1);
    idle(1);
    check("divz_done", {31'd0, BUSY}, 32'd0);
    check("divz_hi", HI_out, 32'hABCD);
    check("divz_lo", LO_out, 32'h55);

    // reset at T+3 of a DIV drops it for good
    cyc(1'b0, 1'b0, 1'b1, OpDiv, 32'd100, 32'd7);
    idle(2);
    cyc(1'b1, 1'b0, 1'b0, OpNone, 32'd0, 32'd0);
    check("rstdiv_busy", {31'd0, BUSY}, 32'd0);
    check("rstdiv_hi", HI_out, 32'd0);
    idle(12);
    check("rstdiv_lo_late", LO_out, 32'd0);
    check("rstdiv_hi_late", HI_out, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 199) == 0);
      rq = ($urandom_range(0, 15) == 0);
      op = 4'($urandom_range(0, 8));
      st = (op inside {OpMult, OpMultu, OpDiv, OpDivu}) ? ($urandom_range(0, 7) != 0)
                                                         : ($urandom_range(0, 15) == 0);
      cyc(rs, rq, st, op, pick(), pick());
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
